// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: state encoding, default
// operand width and the helper that sizes the step counter.
package restoring_divider_pkg;

    localparam int DIV_DEFAULT_W = 4;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_RUN  = 2'd1;
    localparam div_state_t ST_DONE = 2'd2;

    // The counter must hold the value W itself, hence one bit above clog2(W).
    function automatic int div_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/restoring_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try subtracting the divisor and keep the trial only if it did
// not go negative. Purely combinational.
module div_step
    import restoring_divider_pkg::*;
#(
    parameter int W = DIV_DEFAULT_W
) (
    input  logic [W:0]   rem_in,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] trial;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in W+1 bits; the extra top bit of trial acts purely as its sign.
    always_comb begin
        shifted = {rem_in, in_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[W+1];
        rem_out = trial[W+1] ? shifted[W:0] : trial[W:0];
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider. A start pulse in IDLE latches the
// operands; W RUN cycles each retire one quotient bit; DONE presents the
// result with a one-cycle done pulse. Divide by zero skips straight to DONE.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int W = DIV_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = div_cnt_width(W);

    div_state_t   state;
    logic [CW-1:0] cnt;
    logic [W:0]   rem_reg;
    logic [W-1:0] q_reg;
    logic [W-1:0] dvs_reg;

    logic [W:0]   step_rem;
    logic         step_qbit;
    logic [W-1:0] q_next;

    // The quotient register starts out holding the dividend; its MSB is the
    // next dividend bit to shift into the remainder, and quotient bits fill
    // in from the bottom as the dividend bits drain out of the top.
    div_step #(.W(W)) u_step (
        .rem_in  (rem_reg),
        .in_bit  (q_reg[W-1]),
        .divisor (dvs_reg),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // Shifted quotient register including the freshly decided bit.
    always_comb begin
        q_next = {q_reg[W-2:0], step_qbit};
    end

    // FSM, datapath registers and result registers; results only change on
    // the transition into DONE so they hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rem_reg     <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q_reg   <= dividend;
                        dvs_reg <= divisor;
                        rem_reg <= '0;
                        cnt     <= CW'(W);
                        if (divisor == '0) begin
                            state       <= ST_DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rem_reg <= step_rem;
                    q_reg   <= q_next;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= ST_DONE;
                        quotient    <= q_next;
                        remainder   <= step_rem[W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Testbench for restoring_divider (W=4): directed vector table, hand-written
// multi-cycle corner sequences, random operations and a full operand sweep,
// all checked against plain-arithmetic expectations.
module tb_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int nCompared = 0;
    int nMismatched = 0;

    int prevQ = 0;
    int prevR = 0;
    int prevZ = 0;

    typedef struct {
        int dd;
        int dv;
        int q;
        int r;
        int z;
        int lat;
    } vec_t;

    vec_t vecs[10];

    restoring_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of division.
    task automatic model(input int dd, input int dv, output int q, output int r,
                         output int z, output int lat);
        if (dv == 0) begin
            q = (1 << W) - 1;
            r = dd;
            z = 1;
            lat = 1;
        end else begin
            q = dd / dv;
            r = dd % dv;
            z = 0;
            lat = W + 1;
        end
    endtask

    // Pulse start with the given operands at a falling edge, then watch
    // nCycles cycles (cycle 1 follows the sampling edge). Optionally drive a
    // second start pulse during cycle injCycle. Reports done/busy statistics,
    // the outputs seen at the first done, and whether outputs moved early.
    task automatic applyStimulus(input int dd, input int dv, input int injCycle,
                                 input int injDd, input int injDv, input int nCycles,
                                 output int doneCnt, output int firstDone,
                                 output int busyCnt, output int qSeen,
                                 output int rSeen, output int zSeen,
                                 output int earlyChange);
        doneCnt = 0;
        firstDone = 0;
        busyCnt = 0;
        qSeen = -1;
        rSeen = -1;
        zSeen = -1;
        earlyChange = 0;
        @(negedge clk);
        start = 1'b1;
        dividend = W'(dd);
        divisor = W'(dv);
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
        for (int c = 1; c <= nCycles; c++) begin
            if (done) begin
                doneCnt++;
                if (firstDone == 0) begin
                    firstDone = c;
                    qSeen = int'(quotient);
                    rSeen = int'(remainder);
                    zSeen = int'(div_by_zero);
                end
            end else if (firstDone == 0) begin
                if (int'(quotient) != prevQ || int'(remainder) != prevR ||
                    int'(div_by_zero) != prevZ)
                    earlyChange = 1;
            end
            if (busy) busyCnt++;
            if (c == injCycle) begin
                start = 1'b1;
                dividend = W'(injDd);
                divisor = W'(injDv);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_quotient"}, int'(quotient), 0);
        checkOutput({tag, "_remainder"}, int'(remainder), 0);
        checkOutput({tag, "_div_by_zero"}, int'(div_by_zero), 0);
    endtask

    initial begin
        int dc, fd, bc, qs, rs, zs, ec;
        int eq, er, ez, el;
        int ok;

        vecs[0] = '{dd: 13, dv: 3, q: 4, r: 1, z: 0, lat: 5};
        vecs[1] = '{dd: 15, dv: 1, q: 15, r: 0, z: 0, lat: 5};
        vecs[2] = '{dd: 3, dv: 9, q: 0, r: 3, z: 0, lat: 5};
        vecs[3] = '{dd: 7, dv: 0, q: 15, r: 7, z: 1, lat: 1};
        vecs[4] = '{dd: 8, dv: 2, q: 4, r: 0, z: 0, lat: 5};
        vecs[5] = '{dd: 0, dv: 5, q: 0, r: 0, z: 0, lat: 5};
        vecs[6] = '{dd: 0, dv: 0, q: 15, r: 0, z: 1, lat: 1};
        vecs[7] = '{dd: 15, dv: 15, q: 1, r: 0, z: 0, lat: 5};
        vecs[8] = '{dd: 9, dv: 4, q: 2, r: 1, z: 0, lat: 5};
        vecs[9] = '{dd: 14, dv: 13, q: 1, r: 1, z: 0, lat: 5};

        // Power-on reset: outputs must clear without any clock edge.
        #1 rst = 1'b1;
        #2 checkResetOutputs("por_async");
        @(negedge clk);
        checkResetOutputs("por");
        rst = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dd, vecs[i].dv, 0, 0, 0, 8,
                          dc, fd, bc, qs, rs, zs, ec);
            checkOutput($sformatf("vec%0d_done_count", i), dc, 1);
            checkOutput($sformatf("vec%0d_latency", i), fd, vecs[i].lat);
            checkOutput($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].lat);
            checkOutput($sformatf("vec%0d_quotient", i), qs, vecs[i].q);
            checkOutput($sformatf("vec%0d_remainder", i), rs, vecs[i].r);
            checkOutput($sformatf("vec%0d_div_by_zero", i), zs, vecs[i].z);
            checkOutput($sformatf("vec%0d_early_change", i), ec, 0);
            checkOutput($sformatf("vec%0d_hold_quotient", i), int'(quotient), vecs[i].q);
            prevQ = vecs[i].q;
            prevR = vecs[i].r;
            prevZ = vecs[i].z;
        end

        // Second start while busy must be ignored.
        applyStimulus(14, 4, 2, 1, 1, 10, dc, fd, bc, qs, rs, zs, ec);
        checkOutput("busy_restart_done_count", dc, 1);
        checkOutput("busy_restart_latency", fd, 5);
        checkOutput("busy_restart_quotient", qs, 3);
        checkOutput("busy_restart_remainder", rs, 2);
        prevQ = 3; prevR = 2; prevZ = 0;

        // Start during the DONE cycle (DONE->IDLE edge) must be ignored.
        applyStimulus(6, 3, 5, 5, 1, 12, dc, fd, bc, qs, rs, zs, ec);
        checkOutput("done_edge_start_done_count", dc, 1);
        checkOutput("done_edge_start_busy_cycles", bc, 5);
        checkOutput("done_edge_start_quotient", int'(quotient), 2);
        prevQ = 2; prevR = 0; prevZ = 0;

        // Leave nonzero results (including the zero flag) before the abort.
        applyStimulus(7, 0, 0, 0, 0, 4, dc, fd, bc, qs, rs, zs, ec);
        checkOutput("pre_abort_div_by_zero", zs, 1);
        prevQ = 15; prevR = 7; prevZ = 1;

        // Asynchronous reset between edges during RUN aborts the operation.
        @(negedge clk);
        start = 1'b1;
        dividend = 4'd12;
        divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkResetOutputs("abort_async");
        @(negedge clk);
        rst = 1'b0;
        prevQ = 0; prevR = 0; prevZ = 0;
        dc = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) dc++;
            @(negedge clk);
        end
        checkOutput("abort_no_activity", dc, 0);
        applyStimulus(12, 5, 0, 0, 0, 8, dc, fd, bc, qs, rs, zs, ec);
        checkOutput("after_abort_done_count", dc, 1);
        checkOutput("after_abort_latency", fd, 5);
        checkOutput("after_abort_quotient", qs, 2);
        checkOutput("after_abort_remainder", rs, 2);
        prevQ = 2; prevR = 2; prevZ = 0;

        // Random operations with random idle gaps.
        for (int n = 0; n < 30; n++) begin
            int a, b;
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            repeat ($urandom_range(2, 0)) @(negedge clk);
            model(a, b, eq, er, ez, el);
            applyStimulus(a, b, 0, 0, 0, 7, dc, fd, bc, qs, rs, zs, ec);
            ok = (dc == 1 && fd == el && qs == eq && rs == er && zs == ez && ec == 0) ? 1 : 0;
            checkOutput($sformatf("rand_%0d_div_%0d (q=%0d r=%0d z=%0d lat=%0d)",
                                  a, b, qs, rs, zs, fd), ok, 1);
            prevQ = eq; prevR = er; prevZ = ez;
        end

        // Exhaustive sweep of every operand pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(a, b, eq, er, ez, el);
                applyStimulus(a, b, 0, 0, 0, 6, dc, fd, bc, qs, rs, zs, ec);
                ok = (dc == 1 && qs == eq && rs == er && zs == ez) ? 1 : 0;
                if (b != 0 && (qs * b + rs != a || rs >= b)) ok = 0;
                checkOutput($sformatf("sweep_%0d_div_%0d (q=%0d r=%0d z=%0d)",
                                      a, b, qs, rs, zs), ok, 1);
                prevQ = eq; prevR = er; prevZ = ez;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter W, default 4, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, with asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit, a one-cycle request that samples the operands.
REQ-005 SHALL have port dividend, input, W bits, unsigned.
REQ-006 SHALL have port divisor, input, W bits, unsigned.
REQ-007 SHALL have port busy, output, 1 bit, high while a division is in progress.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle pulse when results are valid.
REQ-009 SHALL have port quotient, output, W bits, unsigned.
REQ-010 SHALL have port remainder, output, W bits, unsigned.
REQ-011 SHALL have port div_by_zero, output, 1 bit, flag for the last completed operation.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL:
- latch dividend and divisor;
- clear the partial remainder (W+1 bits);
- load the step counter with W;
- go to RUN, or to DONE if divisor=0.
REQ-014 Each RUN cycle SHALL do one restoring step:
- shift {partial remainder, quotient register} left by 1;
- trial = partial remainder − divisor, at width W+1;
- if trial is non-negative (MSB=0), keep the trial and set the quotient LSB=1;
- otherwise keep the old remainder and set the quotient LSB=0;
- decrement the counter.
REQ-015 RUN SHALL go to DONE after the step in which the counter reaches 0; exactly W RUN cycles.
REQ-016 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-017 Latency SHALL be fixed: start sampled at edge 0 gives done high during cycle W+1 (cycle 5 for W=4); the divide-by-zero path gives done high during cycle 1.
REQ-018 busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-019 Divide by zero SHALL give quotient = all ones, remainder = dividend, and div_by_zero=1.
REQ-020 div_by_zero SHALL be 0 for any nonzero divisor.
REQ-021 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold until the next completion.
REQ-022 start SHALL be ignored while busy=1; an operation in flight is never restarted or corrupted.
REQ-023 start in the same cycle as the DONE→IDLE transition SHALL be ignored; it is accepted only when the FSM is in IDLE.
REQ-024 dividend=0 SHALL complete in W cycles with quotient=0 and remainder=0.
REQ-025 A divisor greater than the dividend SHALL give quotient=0 and remainder=dividend.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force the FSM to IDLE and clear the counter and all internal registers.
REQ-027 rst=1 SHALL force busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0.
REQ-028 Reset during RUN or DONE SHALL abort the operation with no done pulse; the next start after release SHALL behave normally.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state encoding (IDLE, RUN, DONE);
- the default width constant (4);
- the counter width, clog2(W)+1.
REQ-030 One sub-module SHALL exist, div_step: a combinational W+1-bit subtract-and-select producing the next partial remainder and the quotient bit.
REQ-031 All registers SHALL be in restoring_divider, with no other hierarchy.

Verification
REQ-032 Dividend 13, divisor 3, start pulse → busy for 5 cycles, done pulse in cycle 5, quotient=4, remainder=1, div_by_zero=0.
REQ-033 Dividend 15, divisor 1 → quotient=15, remainder=0; then 3/9 → quotient=0, remainder=3; both with done in cycle 5.
REQ-034 Dividend 7, divisor 0 → done in cycle 1, quotient=15, remainder=7, div_by_zero=1; then 8/2 → quotient=4, remainder=0, div_by_zero=0.
REQ-035 Start 14/4, then a second start with 1/1 in cycle 2 → exactly one done pulse, with quotient=3, remainder=2.
REQ-036 Start 12/5, assert rst in cycle 2 between clock edges → outputs zero at once, no done pulse; after release, 12/5 → quotient=2, remainder=2.
REQ-037 Exhaustive sweep of all 256 operand pairs at W=4 → quotient·divisor + remainder = dividend and remainder < divisor for every divisor ≠ 0.
